ex_stage: RTL and testbench



---
 rtl/ex_stage_if.sv | 57 +++++
 rtl/ex_stage.sv | 181 ++++++++++++++++++
 tb/tb_ex_stage.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Bundle of all ID-side inputs, forwarding selects and EX/MEM-side outputs of the execute stage.
// Ports: id_* instruction fields and control, hazard controls (id_stall, ex_flush), fwd_a/fwd_b/wb_result,
//        outputs ex_redirect/ex_redirect_pc and the EX/MEM register contents (mem_*).
interface ex_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    // ID side
    logic            id_valid;
    logic            id_stall;
    logic            ex_flush;
    logic [PC_W-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [2:0]      id_alu_control;
    logic            id_alu_src;
    logic            id_branch;
    logic            id_jump;
    logic [2:0]      id_funct3;
    logic            id_pred_taken;
    logic [4:0]      id_rd;
    logic            id_reg_write;
    logic            id_mem_write;
    logic [1:0]      id_result_src;
    // forwarding controls for the instruction currently in EX
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [XLEN-1:0] wb_result;
    // redirect
    logic            ex_redirect;
    logic [PC_W-1:0] ex_redirect_pc;
    // EX/MEM register
    logic            mem_valid;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_write_data;
    logic [4:0]      mem_rd;
    logic            mem_reg_write;
    logic            mem_mem_write;
    logic [1:0]      mem_result_src;

    modport master (
        output id_valid, id_stall, ex_flush, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_alu_control, id_alu_src, id_branch, id_jump, id_funct3, id_pred_taken,
               id_rd, id_reg_write, id_mem_write, id_result_src, fwd_a, fwd_b, wb_result,
        input  ex_redirect, ex_redirect_pc, mem_valid, mem_alu_result, mem_write_data,
               mem_rd, mem_reg_write, mem_mem_write, mem_result_src
    );

    modport slave (
        input  id_valid, id_stall, ex_flush, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_alu_control, id_alu_src, id_branch, id_jump, id_funct3, id_pred_taken,
               id_rd, id_reg_write, id_mem_write, id_result_src, fwd_a, fwd_b, wb_result,
        output ex_redirect, ex_redirect_pc, mem_valid, mem_alu_result, mem_write_data,
               mem_rd, mem_reg_write, mem_mem_write, mem_result_src
    );
endinterface

// File: rtl/ex_stage.sv
// Purpose: RISC-V execute stage - ID/EX register, forwarding, ALU, branch/jal resolution, EX/MEM register.
// Latency: id_* to mem_* is 2 edges; ex_redirect is combinational from ID/EX (1 edge after capture).
// Backpressure: id_stall/ex_flush/redirect load a bubble into ID/EX; EX/MEM never stalls.
// Ports: clk, rst_n (async active-low), bus (ex_stage_if.slave: ID inputs, forwarding, redirect, mem_* outputs).
module ex_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_stage_if.slave    bus
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [2:0]      alu_control;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [2:0]      funct3;
        logic            pred_taken;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
    } idex_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
    } exmem_t;

    idex_t           r_idex;
    exmem_t          r_exmem;

    idex_t           w_id_in;
    exmem_t          w_exmem_in;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_rs2_fwd;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_diff;
    logic            w_zero;
    logic [XLEN-1:0] w_alu_result;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_target;
    logic            w_cond;
    logic            w_taken;
    logic            w_redirect;

    // 11 falls back to register data, same as 00.
    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                 input logic [XLEN-1:0] reg_val,
                                                 input logic [XLEN-1:0] mem_val,
                                                 input logic [XLEN-1:0] wb_val);
        case (sel)
            2'b01:   return mem_val;
            2'b10:   return wb_val;
            default: return reg_val;
        endcase
    endfunction

    // ------------------------------------------------------------------ ID/EX
    always_comb begin
        w_id_in             = '0;
        w_id_in.valid       = bus.id_valid;
        w_id_in.pc          = bus.id_pc;
        w_id_in.rs1         = bus.id_rs1_data;
        w_id_in.rs2         = bus.id_rs2_data;
        w_id_in.imm         = bus.id_imm;
        w_id_in.alu_control = bus.id_alu_control;
        w_id_in.alu_src     = bus.id_alu_src;
        w_id_in.branch      = bus.id_branch;
        w_id_in.jump        = bus.id_jump;
        w_id_in.funct3      = bus.id_funct3;
        w_id_in.pred_taken  = bus.id_pred_taken;
        w_id_in.rd          = bus.id_rd;
        w_id_in.reg_write   = bus.id_reg_write;
        w_id_in.mem_write   = bus.id_mem_write;
        w_id_in.result_src  = bus.id_result_src;
    end

    // A bubble is an all-zero record: valid, write enables, branch and jump all clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex <= '0;
        end else if (bus.ex_flush || w_redirect || bus.id_stall) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_id_in;
        end
    end

    // ------------------------------------------------------------------ EX
    assign w_a       = fwd_mux(bus.fwd_a, r_idex.rs1, r_exmem.alu_result, bus.wb_result);
    assign w_rs2_fwd = fwd_mux(bus.fwd_b, r_idex.rs2, r_exmem.alu_result, bus.wb_result);
    assign w_b       = r_idex.alu_src ? r_idex.imm : w_rs2_fwd;

    // Branch compare always uses the subtractor, whatever ALUControl says.
    assign w_diff = w_a - w_b;
    assign w_zero = (w_diff == '0);

    always_comb begin
        w_alu_result = '0;
        case (r_idex.alu_control)
            ALU_ADD: w_alu_result = w_a + w_b;
            ALU_SUB: w_alu_result = w_diff;
            ALU_AND: w_alu_result = w_a & w_b;
            ALU_OR:  w_alu_result = w_a | w_b;
            ALU_SLT: w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            default: w_alu_result = '0;
        endcase
    end

    assign w_pc_plus4 = r_idex.pc + PC_W'(4);
    assign w_target   = r_idex.pc + PC_W'($signed(r_idex.imm));

    always_comb begin
        w_cond = 1'b0;
        case (r_idex.funct3)
            F3_BEQ:  w_cond = w_zero;
            F3_BNE:  w_cond = ~w_zero;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken    = r_idex.jump | (r_idex.branch & w_cond);
    assign w_redirect = r_idex.valid & (r_idex.branch | r_idex.jump) & (w_taken != r_idex.pred_taken);

    assign bus.ex_redirect    = w_redirect;
    // Held at zero when idle so the output is quiet out of reset.
    assign bus.ex_redirect_pc = w_redirect ? (w_taken ? w_target : w_pc_plus4) : '0;

    // ------------------------------------------------------------------ EX/MEM
    always_comb begin
        w_exmem_in = '0;
        if (r_idex.valid) begin
            w_exmem_in.valid      = 1'b1;
            w_exmem_in.alu_result = r_idex.jump ? XLEN'(w_pc_plus4) : w_alu_result;
            w_exmem_in.write_data = w_rs2_fwd;
            w_exmem_in.rd         = r_idex.rd;
            w_exmem_in.reg_write  = r_idex.reg_write;
            w_exmem_in.mem_write  = r_idex.mem_write;
            w_exmem_in.result_src = r_idex.result_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exmem <= '0;
        end else begin
            r_exmem <= w_exmem_in;
        end
    end

    assign bus.mem_valid      = r_exmem.valid;
    assign bus.mem_alu_result = r_exmem.alu_result;
    assign bus.mem_write_data = r_exmem.write_data;
    assign bus.mem_rd         = r_exmem.rd;
    assign bus.mem_reg_write  = r_exmem.reg_write;
    assign bus.mem_mem_write  = r_exmem.mem_write;
    assign bus.mem_result_src = r_exmem.result_src;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: ALU vector table, hand-written pipeline sequences, then randomized
// stimulus against an instruction-level reference model.
module tb_ex_stage;
    localparam int XLEN = 32;
    localparam int PC_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

    ex_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_id();
        bus.id_valid = 0; bus.id_stall = 0; bus.ex_flush = 0; bus.id_pc = '0;
        bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0; bus.id_alu_control = '0;
        bus.id_alu_src = 0; bus.id_branch = 0; bus.id_jump = 0; bus.id_funct3 = '0;
        bus.id_pred_taken = 0; bus.id_rd = '0; bus.id_reg_write = 0; bus.id_mem_write = 0;
        bus.id_result_src = '0; bus.fwd_a = '0; bus.fwd_b = '0; bus.wb_result = '0;
    endtask

    task automatic r_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
        bus.id_valid = 1; bus.id_alu_control = code; bus.id_rs1_data = a;
        bus.id_rs2_data = b; bus.id_rd = rd; bus.id_reg_write = 1;
    endtask

    task automatic br(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] f3, input logic pred, input logic jal);
        bus.id_valid = 1; bus.id_pc = pc; bus.id_imm = imm; bus.id_rs1_data = a;
        bus.id_rs2_data = b; bus.id_funct3 = f3; bus.id_pred_taken = pred;
        bus.id_branch = !jal; bus.id_jump = jal; bus.id_alu_control = 3'b001;
        bus.id_rd = jal ? 5'd1 : 5'd0; bus.id_reg_write = jal;
    endtask

    // ---------------------------------------------------------- reference model
    typedef struct packed {
        logic valid; logic [31:0] pc, rs1, rs2, imm; logic [2:0] code; logic src, br, jal;
        logic [2:0] f3; logic pred; logic [4:0] rd; logic rw, mw; logic [1:0] rs;
    } ins_t;

    typedef struct packed {
        logic valid; logic [31:0] res, wdat; logic [4:0] rd; logic rw, mw; logic [1:0] rs;
    } mem_t;

    function automatic logic [31:0] alu_ref(input logic [2:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
        case (code)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] r,
                                         input logic [31:0] m, input logic [31:0] w);
        if (s == 2'd1) return m;
        if (s == 2'd2) return w;
        return r;
    endfunction

    // ---------------------------------------------------------- ALU vector table
    typedef struct {
        logic [2:0] code; logic [31:0] a, b, imm; logic src; logic [31:0] exp;
    } alu_vec_t;
    localparam int NV = 10;
    alu_vec_t tbl [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    initial begin
        ins_t m_ex, nx_ex, d;
        mem_t m_mem, nx_mem;
        logic [31:0] a, r2, b, e_rpc;
        logic taken, e_redir, stall, flush;
        logic [1:0] fa, fb;
        logic [31:0] wb;
        int k;

        tbl[0] = '{3'b001, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'hFFFFFFFE};
        tbl[1] = '{3'b101, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'h1};
        tbl[2] = '{3'b010, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'h1};
        tbl[3] = '{3'b011, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'hFFFFFFFF};
        tbl[4] = '{3'b100, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'h0};
        tbl[5] = '{3'b000, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'h0};
        tbl[6] = '{3'b101, 32'h5, 32'h0, 32'hFFFFFFFD, 1'b1, 32'h0};
        tbl[7] = '{3'b110, 32'h12345678, 32'h1, 32'h0, 1'b0, 32'h0};
        tbl[8] = '{3'b000, 32'h10, 32'h99, 32'hFFFFFFF0, 1'b1, 32'h0};
        tbl[9] = '{3'b101, 32'h1, 32'h80000000, 32'h0, 1'b0, 32'h0};

        clr_id();
        #12;
        chk("reset mem_valid", bus.mem_valid, 0);
        chk("reset mem_alu_result", bus.mem_alu_result, 0);
        chk("reset ex_redirect", bus.ex_redirect, 0);
        chk("reset ex_redirect_pc", bus.ex_redirect_pc, 0);
        chk("reset mem_reg_write", bus.mem_reg_write, 0);
        chk("reset mem_mem_write", bus.mem_mem_write, 0);
        @(negedge clk) rst_n = 1;
        tick();

        // ALU table
        for (int i = 0; i < NV; i++) begin
            clr_id();
            r_op(tbl[i].code, tbl[i].a, tbl[i].b, 5'(i + 1));
            bus.id_imm = tbl[i].imm; bus.id_alu_src = tbl[i].src;
            tick(); clr_id(); tick();
            @(negedge clk);
            chk($sformatf("alu[%0d] result", i), bus.mem_alu_result, tbl[i].exp);
            chk($sformatf("alu[%0d] rd", i), bus.mem_rd, 32'(i + 1));
            chk($sformatf("alu[%0d] valid", i), bus.mem_valid, 1);
            tick();
        end

        // Forwarding: mem and wb sources into an add
        clr_id(); r_op(3'b000, 32'h8, 32'h8, 5'd1); tick();
        clr_id(); r_op(3'b000, 32'hDEAD, 32'hBEEF, 5'd2); tick();
        clr_id(); bus.fwd_a = 2'b01; bus.fwd_b = 2'b10; bus.wb_result = 32'h20;
        @(negedge clk); chk("fwd prior result", bus.mem_alu_result, 32'h10);
        tick(); clr_id();
        @(negedge clk);
        chk("fwd add result", bus.mem_alu_result, 32'h30);
        chk("fwd add write_data", bus.mem_write_data, 32'h20);
        tick();
        // sw with forwarded store data
        clr_id(); r_op(3'b000, 32'h8, 32'h8, 5'd3); tick();
        clr_id(); bus.id_valid = 1; bus.id_rs1_data = 32'h100; bus.id_rs2_data = 32'hBAD;
        bus.id_imm = 32'h4; bus.id_alu_src = 1; bus.id_mem_write = 1; tick();
        clr_id(); bus.fwd_b = 2'b01; tick(); clr_id();
        @(negedge clk);
        chk("sw write_data", bus.mem_write_data, 32'h10);
        chk("sw address", bus.mem_alu_result, 32'h104);
        chk("sw mem_write", bus.mem_mem_write, 1);
        chk("sw reg_write", bus.mem_reg_write, 0);
        tick();

        // beq taken, predicted taken: no redirect
        clr_id(); br(32'h100, 32'hFFFFFFF8, 32'd5, 32'd5, 3'b000, 1, 0); tick(); clr_id();
        @(negedge clk); chk("beq pred ok redirect", bus.ex_redirect, 0); tick();
        // beq taken, predicted not-taken: redirect, younger ID instruction dropped
        clr_id(); br(32'h100, 32'hFFFFFFF8, 32'd5, 32'd5, 3'b000, 0, 0); tick();
        clr_id(); r_op(3'b000, 32'h1, 32'h1, 5'd7);
        @(negedge clk);
        chk("beq mispredict redirect", bus.ex_redirect, 1);
        chk("beq mispredict pc", bus.ex_redirect_pc, 32'hF8);
        tick(); clr_id();
        @(negedge clk);
        chk("beq bubble redirect", bus.ex_redirect, 0);
        chk("beq in mem valid", bus.mem_valid, 1);
        chk("beq in mem reg_write", bus.mem_reg_write, 0);
        tick();
        @(negedge clk); chk("beq dropped younger", bus.mem_valid, 0); tick();
        // bne equal operands predicted taken: redirect to fall-through
        clr_id(); br(32'h100, 32'hFFFFFFF8, 32'd5, 32'd5, 3'b001, 1, 0); tick(); clr_id();
        @(negedge clk);
        chk("bne redirect", bus.ex_redirect, 1);
        chk("bne redirect pc", bus.ex_redirect_pc, 32'h104);
        tick();
        @(negedge clk); chk("bne bubble redirect", bus.ex_redirect, 0); tick();
        // bne unequal, predicted taken: correct
        clr_id(); br(32'h100, 32'h10, 32'd5, 32'd6, 3'b001, 1, 0); tick(); clr_id();
        @(negedge clk); chk("bne taken ok", bus.ex_redirect, 0); tick();
        // jal
        clr_id(); br(32'h40, 32'h20, 32'd0, 32'd0, 3'b000, 0, 1); tick(); clr_id();
        @(negedge clk);
        chk("jal redirect", bus.ex_redirect, 1);
        chk("jal redirect pc", bus.ex_redirect_pc, 32'h60);
        tick();
        @(negedge clk);
        chk("jal link", bus.mem_alu_result, 32'h44);
        chk("jal rd", bus.mem_rd, 1);
        chk("jal reg_write", bus.mem_reg_write, 1);
        tick();

        // Stall: bubble two edges later
        clr_id(); r_op(3'b000, 32'h1, 32'h2, 5'd4); bus.id_mem_write = 1; bus.id_stall = 1;
        tick(); clr_id(); tick();
        @(negedge clk);
        chk("stall mem_valid", bus.mem_valid, 0);
        chk("stall reg_write", bus.mem_reg_write, 0);
        chk("stall mem_write", bus.mem_mem_write, 0);
        tick();

        // Mispredict together with stall
        clr_id(); br(32'h200, 32'h10, 32'd3, 32'd3, 3'b000, 0, 0); tick();
        clr_id(); r_op(3'b000, 32'h1, 32'h1, 5'd9); bus.id_stall = 1;
        @(negedge clk);
        chk("redir+stall redirect", bus.ex_redirect, 1);
        chk("redir+stall pc", bus.ex_redirect_pc, 32'h210);
        tick(); clr_id();
        @(negedge clk);
        chk("redir+stall branch in mem", bus.mem_valid, 1);
        chk("redir+stall bubble redirect", bus.ex_redirect, 0);
        tick();
        @(negedge clk); chk("redir+stall bubble in mem", bus.mem_valid, 0); tick();

        // Flush with a valid EX instruction
        clr_id(); r_op(3'b000, 32'h3, 32'h4, 5'd5); tick();
        clr_id(); r_op(3'b000, 32'h9, 32'h9, 5'd6); bus.ex_flush = 1; tick(); clr_id();
        @(negedge clk);
        chk("flush ex completes", bus.mem_valid, 1);
        chk("flush ex result", bus.mem_alu_result, 32'h7);
        chk("flush ex rd", bus.mem_rd, 5);
        tick();
        @(negedge clk); chk("flush id dropped", bus.mem_valid, 0); tick();

        // Reset mid-stream
        clr_id(); r_op(3'b000, 32'h2, 32'h2, 5'd2); tick();
        clr_id(); br(32'h40, 32'h20, 32'd0, 32'd0, 3'b000, 0, 1); tick();
        clr_id(); r_op(3'b000, 32'h1, 32'h1, 5'd8);
        @(negedge clk);
        chk("pre-reset mem_valid", bus.mem_valid, 1);
        chk("pre-reset redirect", bus.ex_redirect, 1);
        rst_n = 0; #1;
        chk("async reset redirect", bus.ex_redirect, 0);
        chk("async reset redirect_pc", bus.ex_redirect_pc, 0);
        chk("async reset mem_valid", bus.mem_valid, 0);
        chk("async reset alu_result", bus.mem_alu_result, 0);
        chk("async reset rd", bus.mem_rd, 0);
        chk("async reset reg_write", bus.mem_reg_write, 0);
        chk("async reset write_data", bus.mem_write_data, 0);
        @(negedge clk); rst_n = 1;
        clr_id(); r_op(3'b000, 32'd5, 32'd7, 5'd3);
        tick(); clr_id(); tick();
        @(negedge clk);
        chk("post-reset add", bus.mem_alu_result, 32'd12);
        chk("post-reset rd", bus.mem_rd, 3);
        chk("post-reset valid", bus.mem_valid, 1);

        // Randomized run against the model, from a clean reset
        rst_n = 0; clr_id(); #2;
        @(negedge clk); rst_n = 1;
        tick();
        m_ex = '0; m_mem = '0;
        for (int i = 0; i < 3000; i++) begin
            d       = '0;
            d.valid = ($urandom_range(0, 99) < 85);
            d.pc    = $urandom() & 32'hFFFF_FFFC;
            d.rs1   = ($urandom_range(0, 3) == 0) ? (32'($urandom_range(0, 7)) - 32'd4) : $urandom();
            d.rs2   = ($urandom_range(0, 3) == 0) ? d.rs1 : $urandom();
            d.imm   = 32'($urandom_range(0, 511)) - 32'd256;
            d.code  = 3'($urandom_range(0, 7));
            d.src   = 1'($urandom_range(0, 1));
            k       = $urandom_range(0, 9);
            d.br    = (k < 3);
            d.jal   = (k == 3);
            d.f3    = 3'($urandom_range(0, 2));
            d.pred  = 1'($urandom_range(0, 1));
            d.rd    = 5'($urandom_range(0, 31));
            d.rw    = 1'($urandom_range(0, 1));
            d.mw    = 1'($urandom_range(0, 1));
            d.rs    = 2'($urandom_range(0, 3));
            stall   = ($urandom_range(0, 9) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            fa      = 2'($urandom_range(0, 3));
            fb      = 2'($urandom_range(0, 3));
            if (!m_mem.valid && fa == 2'd1) fa = 2'd0;
            if (!m_mem.valid && fb == 2'd1) fb = 2'd0;
            wb      = $urandom();

            bus.id_valid = d.valid; bus.id_pc = d.pc; bus.id_rs1_data = d.rs1;
            bus.id_rs2_data = d.rs2; bus.id_imm = d.imm; bus.id_alu_control = d.code;
            bus.id_alu_src = d.src; bus.id_branch = d.br; bus.id_jump = d.jal;
            bus.id_funct3 = d.f3; bus.id_pred_taken = d.pred; bus.id_rd = d.rd;
            bus.id_reg_write = d.rw; bus.id_mem_write = d.mw; bus.id_result_src = d.rs;
            bus.id_stall = stall; bus.ex_flush = flush;
            bus.fwd_a = fa; bus.fwd_b = fb; bus.wb_result = wb;

            a       = fsel(fa, m_ex.rs1, m_mem.res, wb);
            r2      = fsel(fb, m_ex.rs2, m_mem.res, wb);
            b       = m_ex.src ? m_ex.imm : r2;
            taken   = m_ex.jal || (m_ex.br && ((m_ex.f3 == 3'd0 && a == b) ||
                                               (m_ex.f3 == 3'd1 && a != b)));
            e_redir = m_ex.valid && (m_ex.br || m_ex.jal) && (taken != m_ex.pred);
            e_rpc   = taken ? (m_ex.pc + m_ex.imm) : (m_ex.pc + 32'd4);

            @(negedge clk);
            chk($sformatf("rnd[%0d] redirect", i), bus.ex_redirect, e_redir);
            if (e_redir) chk($sformatf("rnd[%0d] redirect_pc", i), bus.ex_redirect_pc, e_rpc);
            chk($sformatf("rnd[%0d] mem_valid", i), bus.mem_valid, m_mem.valid);
            chk($sformatf("rnd[%0d] reg_write", i), bus.mem_reg_write, m_mem.rw);
            chk($sformatf("rnd[%0d] mem_write", i), bus.mem_mem_write, m_mem.mw);
            if (m_mem.valid) begin
                chk($sformatf("rnd[%0d] alu_result", i), bus.mem_alu_result, m_mem.res);
                chk($sformatf("rnd[%0d] write_data", i), bus.mem_write_data, m_mem.wdat);
                chk($sformatf("rnd[%0d] rd", i), bus.mem_rd, m_mem.rd);
                chk($sformatf("rnd[%0d] result_src", i), bus.mem_result_src, m_mem.rs);
            end

            nx_mem = '0;
            if (m_ex.valid) begin
                nx_mem.valid = 1;
                nx_mem.res   = m_ex.jal ? (m_ex.pc + 32'd4) : alu_ref(m_ex.code, a, b);
                nx_mem.wdat  = r2;
                nx_mem.rd    = m_ex.rd;
                nx_mem.rw    = m_ex.rw;
                nx_mem.mw    = m_ex.mw;
                nx_mem.rs    = m_ex.rs;
            end
            nx_ex = (flush || e_redir || stall) ? '0 : d;

            tick();
            m_ex  = nx_ex;
            m_mem = nx_mem;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
